// File: rtl/coffee_pkg.sv
// Shared types for the coffee machine: drink codes, sequencer states and recipe masks.
package coffee_pkg;

  typedef enum logic [2:0] {
    CoffeeEspresso   = 3'b001,
    CoffeeAmericano  = 3'b010,
    CoffeeCappuccino = 3'b011,
    CoffeeMocha      = 3'b100
  } coffee_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StWater,
    StCoffee,
    StMilk,
    StChoco,
    StSugar,
    StDone,
    StErr
  } seq_state_e;

  typedef struct packed {
    logic water;
    logic long_water;
    logic coffee;
    logic milk;
    logic choco;
  } recipe_t;

endpackage

// File: rtl/coffee_recipe_rom.sv
// Combinational drink-code decoder: maps a coffee_type code to its phase mask.
module coffee_recipe_rom
  import coffee_pkg::*;
(
  input  logic [2:0] coffee_type_i,
  output recipe_t    recipe_o,
  output logic       valid_o
);

  always_comb begin
    recipe_o = '0;
    valid_o  = 1'b1;
    case (coffee_type_i)
      CoffeeEspresso:   recipe_o = '{water: 1'b1, long_water: 1'b0, coffee: 1'b1,
                                     milk: 1'b0, choco: 1'b0};
      CoffeeAmericano:  recipe_o = '{water: 1'b1, long_water: 1'b1, coffee: 1'b1,
                                     milk: 1'b0, choco: 1'b0};
      CoffeeCappuccino: recipe_o = '{water: 1'b1, long_water: 1'b0, coffee: 1'b1,
                                     milk: 1'b1, choco: 1'b0};
      CoffeeMocha:      recipe_o = '{water: 1'b1, long_water: 1'b0, coffee: 1'b1,
                                     milk: 1'b1, choco: 1'b1};
      default:          valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/coffee_dispense_sequencer.sv
// Brew sequencer: latches a recipe on start and runs the enabled valve phases in fixed order.
module coffee_dispense_sequencer
  import coffee_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned T_WATER      = 8,
  parameter int unsigned T_WATER_LONG = 16,
  parameter int unsigned T_COFFEE     = 4,
  parameter int unsigned T_MILK       = 6,
  parameter int unsigned T_CHOCO      = 4,
  parameter int unsigned T_SUGAR      = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] coffee_type,
  input  logic       sugar_req,
  output logic       water,
  output logic       coffee,
  output logic       milk,
  output logic       chocolate,
  output logic       sugar,
  output logic       busy,
  output logic       finished,
  output logic       error
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  recipe_t          recipe_q, recipe_d;
  logic             sugar_q, sugar_d;

  recipe_t          rom_recipe;
  logic             rom_valid;
  logic [CNT_W-1:0] phase_len;

  coffee_recipe_rom u_rom (
    .coffee_type_i (coffee_type),
    .recipe_o      (rom_recipe),
    .valid_o       (rom_valid)
  );

  // First enabled phase strictly after cur; StIdle means "before water".
  function automatic seq_state_e next_phase(seq_state_e cur, recipe_t r, logic s);
    seq_state_e nxt;
    nxt = StDone;
    if (cur != StSugar && s) nxt = StSugar;
    if (cur inside {StIdle, StWater, StCoffee, StMilk} && r.choco) nxt = StChoco;
    if (cur inside {StIdle, StWater, StCoffee} && r.milk) nxt = StMilk;
    if (cur inside {StIdle, StWater} && r.coffee) nxt = StCoffee;
    if (cur == StIdle && r.water) nxt = StWater;
    return nxt;
  endfunction

  always_comb begin
    phase_len = CNT_W'(1);
    case (state_q)
      StWater:  phase_len = recipe_q.long_water ? CNT_W'(T_WATER_LONG) : CNT_W'(T_WATER);
      StCoffee: phase_len = CNT_W'(T_COFFEE);
      StMilk:   phase_len = CNT_W'(T_MILK);
      StChoco:  phase_len = CNT_W'(T_CHOCO);
      StSugar:  phase_len = CNT_W'(T_SUGAR);
      default:  phase_len = CNT_W'(1);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    recipe_d = recipe_q;
    sugar_d  = sugar_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (rom_valid) begin
            recipe_d = rom_recipe;
            sugar_d  = sugar_req;
            state_d  = next_phase(StIdle, rom_recipe, sugar_req);
            cnt_d    = '0;
          end else begin
            state_d = StErr;
          end
        end
      end
      StWater, StCoffee, StMilk, StChoco, StSugar: begin
        if (cnt_q == phase_len - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = next_phase(state_q, recipe_q, sugar_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone, StErr: state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      recipe_q <= '0;
      sugar_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      recipe_q <= recipe_d;
      sugar_q  <= sugar_d;
    end
  end

  assign water     = (state_q == StWater);
  assign coffee    = (state_q == StCoffee);
  assign milk      = (state_q == StMilk);
  assign chocolate = (state_q == StChoco);
  assign sugar     = (state_q == StSugar);
  assign busy      = (state_q != StIdle);
  assign finished  = (state_q == StDone);
  assign error     = (state_q == StErr);

endmodule

// File: tb/tb_coffee_dispense_sequencer.sv
// Directed bench for coffee_dispense_sequencer; outputs are sampled on the falling edge.
module tb_coffee_dispense_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] coffee_type;
  logic       sugar_req;
  logic       water, coffee, milk, chocolate, sugar, busy, finished, error;

  int n_cmp = 0;
  int n_err = 0;

  // {water, coffee, milk, chocolate, sugar, busy, finished, error}
  localparam logic [7:0] OW    = 8'b1000_0100;
  localparam logic [7:0] OC    = 8'b0100_0100;
  localparam logic [7:0] OM    = 8'b0010_0100;
  localparam logic [7:0] OCH   = 8'b0001_0100;
  localparam logic [7:0] OS    = 8'b0000_1100;
  localparam logic [7:0] ODONE = 8'b0000_0110;
  localparam logic [7:0] OERR  = 8'b0000_0101;
  localparam logic [7:0] OIDLE = 8'b0000_0000;

  logic [7:0] obs;
  assign obs = {water, coffee, milk, chocolate, sugar, busy, finished, error};

  coffee_dispense_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .coffee_type (coffee_type),
    .sugar_req   (sugar_req),
    .water       (water),
    .coffee      (coffee),
    .milk        (milk),
    .chocolate   (chocolate),
    .sugar       (sugar),
    .busy        (busy),
    .finished    (finished),
    .error       (error)
  );

  always #5 clock = ~clock;

  task automatic check_now(input string tag, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Checks n consecutive cycles, each sampled at its falling edge.
  task automatic span(input string tag, input int n, input logic [7:0] exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_now(tag, exp);
    end
  endtask

  // One-cycle start; afterwards the inputs are scrambled to show they are not re-sampled.
  task automatic issue(input logic [2:0] typ, input logic sreq);
    @(negedge clock);
    start       = 1'b1;
    coffee_type = typ;
    sugar_req   = sreq;
    @(posedge clock);
    #1;
    start       = 1'b0;
    coffee_type = 3'b111;
    sugar_req   = ~sreq;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    coffee_type = 3'b000;
    sugar_req   = 1'b0;
    #1;
    check_now("reset_state", OIDLE);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    span("idle_after_reset", 2, OIDLE);

    // Espresso, no sugar
    issue(3'b001, 1'b0);
    span("esp_water", 8, OW);
    span("esp_coffee", 4, OC);
    span("esp_done", 1, ODONE);
    span("esp_idle", 2, OIDLE);

    // Mocha with sugar
    issue(3'b100, 1'b1);
    span("mocha_water", 8, OW);
    span("mocha_coffee", 4, OC);
    span("mocha_milk", 6, OM);
    span("mocha_choco", 4, OCH);
    span("mocha_sugar", 2, OS);
    span("mocha_done", 1, ODONE);
    span("mocha_idle", 2, OIDLE);

    // Americano uses the long water phase
    issue(3'b010, 1'b0);
    span("amer_water", 16, OW);
    span("amer_coffee", 4, OC);
    span("amer_done", 1, ODONE);
    span("amer_idle", 2, OIDLE);

    // Invalid codes
    issue(3'b000, 1'b1);
    span("inv000_err", 1, OERR);
    span("inv000_idle", 2, OIDLE);
    issue(3'b111, 1'b0);
    span("inv111_err", 1, OERR);
    span("inv111_idle", 2, OIDLE);

    // Cappuccino with a second start (mocha + sugar) sampled while busy
    issue(3'b011, 1'b0);
    span("busy_water_a", 4, OW);
    start       = 1'b1;
    coffee_type = 3'b100;
    sugar_req   = 1'b1;
    span("busy_water_b", 1, OW);
    start = 1'b0;
    span("busy_water_c", 3, OW);
    span("busy_coffee", 4, OC);
    span("busy_milk", 6, OM);
    span("busy_done", 1, ODONE);
    span("busy_idle", 2, OIDLE);

    // Asynchronous reset in the middle of the milk phase
    issue(3'b011, 1'b0);
    span("rst_water", 8, OW);
    span("rst_coffee", 4, OC);
    span("rst_milk", 3, OM);
    #1;
    reset = 1'b1;
    #1;
    check_now("rst_async_clear", OIDLE);
    span("rst_held", 2, OIDLE);
    reset = 1'b0;
    span("rst_released", 1, OIDLE);

    issue(3'b001, 1'b0);
    span("post_rst_water", 8, OW);
    span("post_rst_coffee", 4, OC);
    span("post_rst_done", 1, ODONE);
    span("post_rst_idle", 2, OIDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
